// File: rtl/adc_frame_packer.sv
// Packs qualified ADC samples LSB-first into words, delimits frames on eof,
// and buffers words in a first-word-fall-through FIFO behind a valid/ready port.
module adc_frame_packer #(
    parameter int ADC_W      = 4,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_en,
    input  logic [ADC_W-1:0]                  adc_in,
    input  logic                              eof,
    output logic [WORD_W-1:0]                 m_data,
    output logic [$clog2(WORD_W/ADC_W):0]     m_nsamp,
    output logic                              m_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  sample_cnt,
    output logic [CNT_W-1:0]                  frame_cnt
);
    localparam int N     = WORD_W / ADC_W;
    localparam int NS_W  = $clog2(N) + 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] word_s;
    logic [NS_W-1:0]   fill_s, push_nsamp_s;
    logic              push_s, push_last_s, push_ok_s, pop_s;

    logic [WORD_W-1:0] data_mem_q  [FIFO_DEPTH];
    logic [NS_W-1:0]   nsamp_mem_q [FIFO_DEPTH];
    logic              last_mem_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d, frame_cnt_q, frame_cnt_d;

    // Packer: pack_q keeps unused lanes zero, so a partial or empty word needs no masking
    always_comb begin
        word_s = pack_q;
        if (sample_en) begin
            word_s[idx_q*ADC_W +: ADC_W] = adc_in;
        end else begin
            word_s = pack_q;
        end
        fill_s       = NS_W'(idx_q) + NS_W'(sample_en);
        push_s       = 1'b0;
        push_nsamp_s = '0;
        push_last_s  = 1'b0;
        if (sample_en && (idx_q == IDX_W'(N - 1))) begin
            push_s       = 1'b1;
            push_nsamp_s = NS_W'(N);
            push_last_s  = eof;
        end else if (eof) begin
            push_s       = 1'b1;
            push_nsamp_s = fill_s;
            push_last_s  = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (push_s) begin
            idx_d  = '0;
            pack_d = '0;
        end else if (sample_en) begin
            idx_d  = idx_q + IDX_W'(1);
            pack_d = word_s;
        end else begin
            idx_d  = idx_q;
            pack_d = pack_q;
        end
    end

    // FIFO control and frame/sample counters
    always_comb begin
        pop_s     = m_valid && m_ready;
        push_ok_s = push_s && ((count_q < (PTR_W+1)'(FIFO_DEPTH)) || pop_s);
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d   = count_q + (PTR_W+1)'(push_ok_s) - (PTR_W+1)'(pop_s);
        overflow_d = overflow_q || (push_s && !push_ok_s);
        frame_cnt_d = eof ? (frame_cnt_q + CNT_W'(1)) : frame_cnt_q;
        if (eof) begin
            sample_cnt_d = '0;
        end else if (sample_en && (sample_cnt_q != '1)) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end else begin
            sample_cnt_d = sample_cnt_q;
        end
    end

    // State registers, including FIFO storage
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            pack_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            sample_cnt_q <= '0;
            frame_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[i]  <= '0;
                nsamp_mem_q[i] <= '0;
                last_mem_q[i]  <= 1'b0;
            end
        end else begin
            idx_q        <= idx_d;
            pack_q       <= pack_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            sample_cnt_q <= sample_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            if (push_ok_s) begin
                data_mem_q[wr_ptr_q]  <= word_s;
                nsamp_mem_q[wr_ptr_q] <= push_nsamp_s;
                last_mem_q[wr_ptr_q]  <= push_last_s;
            end
        end
    end

    assign m_data     = data_mem_q[rd_ptr_q];
    assign m_nsamp    = nsamp_mem_q[rd_ptr_q];
    assign m_last     = last_mem_q[rd_ptr_q];
    assign m_valid    = (count_q != '0);
    assign overflow   = overflow_q;
    assign sample_cnt = sample_cnt_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: a behavioural model queues expected
// words as stimulus is driven; a monitor compares the FIFO head against it.
module tb_adc_frame_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_en = 1'b0;
    logic [3:0]  adc_in = 4'd0;
    logic        eof = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_nsamp;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        overflow;
    logic [15:0] sample_cnt;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  n;
        logic        l;
    } exp_t;

    exp_t        q[$];
    int          occ = 0;
    int          midx = 0;
    logic [31:0] mword = 32'd0;
    logic [15:0] msc = 16'd0;
    logic [15:0] mfc = 16'd0;
    logic        movf = 1'b0;
    int          total = 0;
    int          bad = 0;

    adc_frame_packer dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .adc_in(adc_in), .eof(eof),
        .m_data(m_data), .m_nsamp(m_nsamp), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready), .overflow(overflow), .sample_cnt(sample_cnt),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: head must match the oldest expected word; pop on handshake
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected got data=%h nsamp=%0d last=%0b exp=none", m_data, m_nsamp, m_last);
            end else if (m_data !== q[0].d || m_nsamp !== q[0].n || m_last !== q[0].l) begin
                bad++;
                $display("FAIL mon_head got data=%h nsamp=%0d last=%0b exp data=%h nsamp=%0d last=%0b",
                         m_data, m_nsamp, m_last, q[0].d, q[0].n, q[0].l);
            end
            if (m_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic do_reset();
        rst = 1'b1; sample_en = 1'b0; eof = 1'b0; m_ready = 1'b0; adc_in = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); occ = 0; midx = 0; mword = 32'd0; msc = 16'd0; mfc = 16'd0; movf = 1'b0;
    endtask

    task automatic drive(input logic en, input logic [3:0] val, input logic e, input logic rdy);
        logic [31:0] w;
        logic [3:0]  ns;
        logic        lst, push, pop;
        exp_t        ent;
        sample_en = en; adc_in = val; eof = e; m_ready = rdy;
        w = mword;
        if (en) w = w | ({28'd0, val} << (4 * midx));
        push = 1'b0; ns = 4'd0; lst = 1'b0;
        if (en && midx == 7) begin
            push = 1'b1; ns = 4'd8; lst = e;
        end else if (e) begin
            push = 1'b1; ns = 4'(midx + (en ? 1 : 0)); lst = 1'b1;
        end
        pop = (occ > 0) && rdy;
        if (push) begin
            if (occ < 8 || pop) begin
                ent.d = w; ent.n = ns; ent.l = lst;
                q.push_back(ent);
                occ++;
            end else begin
                movf = 1'b1;
            end
        end
        if (pop) occ--;
        if (push) begin
            midx = 0; mword = 32'd0;
        end else if (en) begin
            midx++; mword = w;
        end
        if (e) msc = 16'd0;
        else if (en && msc != 16'hFFFF) msc++;
        if (e) mfc++;
        @(posedge clk); #1;
        total += 4;
        if (m_valid !== (occ != 0)) begin bad++; $display("FAIL drv_valid got=%0b exp=%0b", m_valid, occ != 0); end
        if (overflow !== movf) begin bad++; $display("FAIL drv_overflow got=%0b exp=%0b", overflow, movf); end
        if (sample_cnt !== msc) begin bad++; $display("FAIL drv_sample_cnt got=%0d exp=%0d", sample_cnt, msc); end
        if (frame_cnt !== mfc) begin bad++; $display("FAIL drv_frame_cnt got=%0d exp=%0d", frame_cnt, mfc); end
    endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (m_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rst_flags got valid=%0b ovf=%0b exp=0 0", m_valid, overflow);
        end
        if (m_data !== 32'd0 || m_nsamp !== 4'd0 || m_last !== 1'b0) begin
            bad++; $display("FAIL rst_head got data=%h nsamp=%0d last=%0b exp=0", m_data, m_nsamp, m_last);
        end
        if (sample_cnt !== 16'd0) begin bad++; $display("FAIL rst_sample_cnt got=%0d exp=0", sample_cnt); end
        if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
    endtask

    task automatic test_full_word();
        for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), 1'b0, 1'b1);
        total += 2;
        if (m_data !== 32'h87654321 || m_nsamp !== 4'd8 || m_last !== 1'b0) begin
            bad++; $display("FAIL full_word got data=%h nsamp=%0d last=%0b exp=87654321 8 0", m_data, m_nsamp, m_last);
        end
        if (sample_cnt !== 16'd8) begin bad++; $display("FAIL full_word_cnt got=%0d exp=8", sample_cnt); end
    endtask

    task automatic test_partial_eof();
        drive(1'b1, 4'hA, 1'b0, 1'b1);
        drive(1'b1, 4'hB, 1'b0, 1'b1);
        drive(1'b1, 4'hC, 1'b1, 1'b1);
        total += 2;
        if (m_data !== 32'h00000CBA || m_nsamp !== 4'd3 || m_last !== 1'b1) begin
            bad++; $display("FAIL partial_eof got data=%h nsamp=%0d last=%0b exp=00000cba 3 1", m_data, m_nsamp, m_last);
        end
        if (frame_cnt !== 16'd1 || sample_cnt !== 16'd0) begin
            bad++; $display("FAIL partial_eof_cnt got frame=%0d samp=%0d exp=1 0", frame_cnt, sample_cnt);
        end
    endtask

    task automatic test_marker();
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        total++;
        if (m_valid !== 1'b1 || m_data !== 32'd0 || m_nsamp !== 4'd0 || m_last !== 1'b1) begin
            bad++; $display("FAIL marker got valid=%0b data=%h nsamp=%0d last=%0b exp=1 0 0 1", m_valid, m_data, m_nsamp, m_last);
        end
        for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), (i == 8), 1'b1);
        total++;
        if (m_data !== 32'h87654321 || m_nsamp !== 4'd8 || m_last !== 1'b1) begin
            bad++; $display("FAIL eof_full got data=%h nsamp=%0d last=%0b exp=87654321 8 1", m_data, m_nsamp, m_last);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        total += 2;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL no_extra_marker got valid=%0b exp=0", m_valid); end
        if (frame_cnt !== 16'd3) begin bad++; $display("FAIL marker_frames got=%0d exp=3", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 12; i++) drive(1'b0, 4'd0, 1'b0, 1'b1);
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d left exp=0", q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 72; i++) drive(1'b1, 4'(i % 16), 1'b0, 1'b0);
        total += 2;
        if (m_valid !== 1'b1 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_flags got valid=%0b ovf=%0b exp=1 1", m_valid, overflow);
        end
        if (m_data !== 32'h76543210) begin bad++; $display("FAIL ovf_head got=%h exp=76543210", m_data); end
        for (int i = 0; i < 10; i++) drive(1'b0, 4'd0, 1'b0, 1'b1);
        total += 2;
        if (q.size() != 0) begin bad++; $display("FAIL ovf_drain got=%0d left exp=0", q.size()); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 72; i++) drive(1'b1, 4'(i % 16), 1'b0, (i == 71));
        total++;
        if (overflow !== 1'b0 || m_valid !== 1'b1) begin
            bad++; $display("FAIL full_pop got ovf=%0b valid=%0b exp=0 1", overflow, m_valid);
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 4'd0, 1'b0, 1'b1);
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL full_pop_drain got=%0d left exp=0", q.size()); end
    endtask

    task automatic test_reset_midword();
        for (int i = 1; i <= 5; i++) drive(1'b1, 4'(i + 8), 1'b0, 1'b1);
        do_reset();
        total += 2;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", m_valid); end
        if (sample_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            bad++; $display("FAIL midrst_cnt got samp=%0d frame=%0d exp=0 0", sample_cnt, frame_cnt);
        end
        for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        total++;
        if (m_data !== 32'h87654321 || m_nsamp !== 4'd8) begin
            bad++; $display("FAIL midrst_repack got data=%h nsamp=%0d exp=87654321 8", m_data, m_nsamp);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b0, 1'b1);
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL midrst_drain got=%0d left exp=0", q.size()); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_full_word();
        test_partial_eof();
        test_marker();
        test_back_to_back();
        test_overflow();
        test_reset();
        test_full_pop();
        test_reset_midword();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
- Downstream consumer of the ADC counter's 4-bit output codes.
- Qualifies samples with the controller's ADC enable and end-of-frame (EoF) signals.
- Packs consecutive samples LSB-first into 32-bit words and buffers them in a small first-word-fall-through (FWFT) FIFO.
- Presents words on a valid/ready stream, with frame delimiting and overflow reporting, for the host readout path.

Parameters:
- ADC_W, 4: width of one ADC sample.
- WORD_W, 32: packed output word width; must be an integer multiple of ADC_W.
- FIFO_DEPTH, 8: number of output words buffered; power of two, at least 2.
- CNT_W, 16: width of the sample and frame counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_en  in  1  ADC enable; adc_in is accepted on every clk edge where this is 1.
- adc_in  in  ADC_W  ADC code.
- eof  in  1  single-cycle end-of-frame pulse.
- m_data  out  WORD_W  packed word.
- m_nsamp  out  $clog2(WORD_W/ADC_W)+1  number of valid samples in m_data.
- m_last  out  1  word closes a frame.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts the head word.
- overflow  out  1  sticky: a word was dropped.
- sample_cnt  out  CNT_W  samples accepted in the current frame.
- frame_cnt  out  CNT_W  frames closed since reset.

Behaviour:
- Definitions: N = WORD_W/ADC_W (8 by default); lane k is bits [k*ADC_W +: ADC_W].
- Reset: while rst=1 on a clk edge, all of the following are cleared:
  - packer lane index and packer contents;
  - FIFO read/write pointers and occupancy;
  - overflow, sample_cnt, frame_cnt;
  - m_valid, m_data, m_nsamp, m_last (all 0).
  - Reset mid-word discards the partial word; nothing is emitted for it.
- Packing:
  - Each accepted sample is written to lane idx; idx increments.
  - The first sample of a word goes to lane 0.
- Word completion (internal push):
  - On the edge where the N-th sample is accepted, the complete word is pushed with nsamp=N and last=eof.
  - idx returns to 0.
- EoF:
  - sample_en and eof in the same cycle: the sample is packed first and belongs to the closing frame.
  - eof with a partial word (idx>0 after that cycle's sample): push the word with unused lanes zero, nsamp = filled lanes, last=1.
  - eof with nothing pending (idx=0 and no sample this cycle, or the word just completed pushes with last=1): if nothing was pushed this edge, push a marker word 0 with nsamp=0, last=1.
  - Hence every eof yields exactly one last=1 word.
- Counters:
  - frame_cnt increments on every eof edge and wraps.
  - sample_cnt increments per accepted sample, saturating at all-ones.
  - On an eof edge sample_cnt loads 0; the eof-cycle sample is not counted into the next frame.
- FIFO:
  - FWFT; the head word, nsamp and last are stored together.
  - A pushed word is visible at the output (m_valid=1) on the cycle after the push edge when the FIFO was empty.
  - Pop: m_valid & m_ready on an edge.
  - Push is accepted if occupancy < FIFO_DEPTH, or if a pop occurs on the same edge (full + simultaneous pop + push: accepted, occupancy unchanged).
  - Otherwise the word is dropped and overflow is set; overflow stays 1 until rst.
  - Packing and counters continue regardless of overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Output hold: m_data, m_nsamp, m_last are stable while m_valid=1 and m_ready=0.
- Latency: last sample edge to m_valid=1 is 1 cycle (FIFO empty).

Test Plan:
- Samples 1,2,3,4,5,6,7,8 on consecutive cycles, m_ready=1 -> one word m_data=0x87654321, m_nsamp=8, m_last=0; sample_cnt=8.
- Samples 0xA,0xB,0xC, eof asserted with 0xC -> m_data=0x00000CBA, m_nsamp=3, m_last=1; frame_cnt=1, sample_cnt=0 next cycle.
- eof alone with idx=0 -> m_data=0, m_nsamp=0, m_last=1; 8 samples with eof on the 8th -> a single word, m_nsamp=8, m_last=1, no extra marker.
- m_ready=0, push 9 full words (samples 0..F repeating) -> m_valid stays 1, first 8 words intact in order, 9th dropped, overflow=1 until rst.
- FIFO full, m_ready=1 on the same edge as the 9th push -> push accepted, overflow=0, all 9 words drained in order.
- 5 samples then rst=1 for 1 cycle -> no word emitted, m_valid=0, sample_cnt=frame_cnt=0; subsequent 8 samples pack from lane 0.
